// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [3:0] WEN_NONE = 4'b0000;

  // Latency counter width; covers the full legal latency range.
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned MAX_LATENCY = 7;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: on contention, pick the side that did not win last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick,
  output logic any
);

  // Lone requester always wins; contention alternates away from 'last'.
  always_comb begin
    any  = req0 | req1;
    pick = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data
// load/store, with round-robin arbitration and a fixed-latency wait per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wen,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Reject latencies the counter cannot represent.
  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..7");
  end

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic   pick;
  logic   any;
  owner_t winner;

  rr_pick2 u_pick (
    .req0 (i_req),
    .req1 (d_req),
    .last (last_q == OWN_DATA),
    .pick (pick),
    .any  (any)
  );

  assign winner = pick ? OWN_DATA : OWN_INST;

  // State, owner, round-robin history and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_DATA;
      last_q  <= OWN_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; everything held at zero while in reset.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_wen   = WEN_NONE;
    mem_addr  = '0;
    mem_wdata = '0;

    if (!reset) begin
      // Read data follows the current owner; the other side sees zero.
      if (owner_q == OWN_INST) begin
        i_rdata = mem_rdata;
      end else begin
        d_rdata = mem_rdata;
      end

      case (state_q)
        IDLE: begin
          if (any) begin
            mem_en  = 1'b1;
            owner_d = winner;
            last_d  = winner;
            cnt_d   = CNT_W'(MEM_LATENCY);
            state_d = WAIT;
            if (winner == OWN_DATA) begin
              d_gnt     = 1'b1;
              mem_addr  = d_addr;
              mem_wen   = d_wen;
              mem_wdata = d_wdata;
            end else begin
              i_gnt     = 1'b1;
              mem_addr  = i_addr;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            if (owner_q == OWN_INST) begin
              i_rvalid = 1'b1;
            end else begin
              d_rvalid = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (latency 1 and 3), each
// with a small memory model and a scoreboard of expected read-valid pulses.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        side;   // 0 = instruction, 1 = data
    logic        chkd;   // compare read data
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Instance 1 (latency 1)
  logic        i_req1, i_gnt1, i_rvalid1, d_req1, d_gnt1, d_rvalid1, m1_en;
  logic [31:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  d_wen1, m1_wen;
  // Instance 3 (latency 3)
  logic        i_req3, i_gnt3, i_rvalid3, d_req3, d_gnt3, d_rvalid3, m3_en;
  logic [31:0] i_addr3, i_rdata3, d_addr3, d_wdata3, d_rdata3, m3_addr, m3_wdata, m3_rdata;
  logic [3:0]  d_wen3, m3_wen;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_addr(d_addr1), .d_wen(d_wen1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(m1_en), .mem_wen(m1_wen), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_addr(d_addr3), .d_wen(d_wen3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(m3_en), .mem_wen(m3_wen), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata)
  );

  // Reset contents of every memory word.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h40) return 32'h3C01_0001;
    return 32'hC0DE_0000 | {24'h0, a[9:2]};
  endfunction

  // Memory models: preload in reset, byte writes, read latency 1 and 3.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p1, p3a, p3b, p3c;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem1[k] <= word(32'(k) << 2);
      p1 <= '0;
    end else if (m1_en) begin
      p1 <= mem1[m1_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (m1_wen[b]) mem1[m1_addr[9:2]][8*b +: 8] <= m1_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem3[k] <= word(32'(k) << 2);
      p3a <= '0; p3b <= '0; p3c <= '0;
    end else begin
      if (m3_en) begin
        p3a <= mem3[m3_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (m3_wen[b]) mem3[m3_addr[9:2]][8*b +: 8] <= m3_wdata[8*b +: 8];
      end
      p3b <= p3a;
      p3c <= p3b;
    end
  end

  assign m1_rdata = p1;
  assign m3_rdata = p3c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard for instance 1: every rvalid must match the queue head.
  task automatic mon1();
    exp_t e;
    if (i_rvalid1 || d_rvalid1) begin
      chk("rv1_onehot", 32'(i_rvalid1 & d_rvalid1), 32'd0);
      chk("rv1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rv1_cycle", 32'(cyc_n), 32'(e.due));
        chk("rv1_side", 32'(d_rvalid1), 32'(e.side));
        if (e.side) chk("rv1_i_rdata_zero", i_rdata1, 32'd0);
        else        chk("rv1_d_rdata_zero", d_rdata1, 32'd0);
        if (e.chkd) chk("rv1_data", e.side ? d_rdata1 : i_rdata1, e.data);
      end
    end else if (q1.size() > 0 && q1[0].due == cyc_n) begin
      chk("rv1_missing", 32'(i_rvalid1 | d_rvalid1), 32'd1);
      void'(q1.pop_front());
    end
  endtask

  // Scoreboard for instance 3.
  task automatic mon3();
    exp_t e;
    if (i_rvalid3 || d_rvalid3) begin
      chk("rv3_onehot", 32'(i_rvalid3 & d_rvalid3), 32'd0);
      chk("rv3_pending", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("rv3_cycle", 32'(cyc_n), 32'(e.due));
        chk("rv3_side", 32'(d_rvalid3), 32'(e.side));
        if (e.chkd) chk("rv3_data", e.side ? d_rdata3 : i_rdata3, e.data);
      end
    end else if (q3.size() > 0 && q3[0].due == cyc_n) begin
      chk("rv3_missing", 32'(i_rvalid3 | d_rvalid3), 32'd1);
      void'(q3.pop_front());
    end
  endtask

  task automatic settle();
    @(negedge clk);
    mon1();
    mon3();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    i_req1 = 1'b1; d_req1 = 1'b1; i_addr1 = 32'h44; d_addr1 = 32'h200; d_wen1 = 4'hF; d_wdata1 = 32'h1234;
    i_req3 = 1'b1; d_req3 = 1'b1; i_addr3 = 32'h44; d_addr3 = 32'h200; d_wen3 = 4'hF; d_wdata3 = 32'h1234;
    #2;
    // Outputs forced quiet while reset is held, even with requests pending.
    chk("rst_i_gnt1", 32'(i_gnt1), 32'd0);
    chk("rst_d_gnt1", 32'(d_gnt1), 32'd0);
    chk("rst_mem_en1", 32'(m1_en), 32'd0);
    chk("rst_mem_wen1", 32'(m1_wen), 32'd0);
    chk("rst_mem_addr1", m1_addr, 32'd0);
    chk("rst_mem_wdata1", m1_wdata, 32'd0);
    chk("rst_d_gnt3", 32'(d_gnt3), 32'd0);
    i_req1 = 1'b0; d_req1 = 1'b0; d_wen1 = 4'h0; d_wdata1 = '0;
    i_req3 = 1'b0; d_req3 = 1'b0; d_wen3 = 4'h0; d_wdata3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    settle();
    chk("idle_mem_en1", 32'(m1_en), 32'd0);
    chk("idle_rvalid1", 32'(i_rvalid1 | d_rvalid1), 32'd0);
    adv();

    // Lone instruction read, latency 1.
    i_req1 = 1'b1; i_addr1 = 32'h40;
    settle();
    chk("t1_i_gnt", 32'(i_gnt1), 32'd1);
    chk("t1_d_gnt", 32'(d_gnt1), 32'd0);
    chk("t1_mem_en", 32'(m1_en), 32'd1);
    chk("t1_mem_addr", m1_addr, 32'h40);
    chk("t1_mem_wen", 32'(m1_wen), 32'd0);
    q1.push_back('{1'b0, 1'b1, 32'h3C01_0001, cyc_n + 1});
    adv();
    i_req1 = 1'b0;
    settle();
    chk("t1_d_rvalid", 32'(d_rvalid1), 32'd0);
    chk("t1_wait_gnt", 32'(i_gnt1 | d_gnt1), 32'd0);
    adv();

    // Contention straight after reset: I, D, I, D every other cycle.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    i_req1 = 1'b1; d_req1 = 1'b1; i_addr1 = 32'h44; d_addr1 = 32'h200; d_wen1 = 4'h0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_i_gnt", 32'(i_gnt1), 32'((k % 4) == 0));
      chk("t2_d_gnt", 32'(d_gnt1), 32'((k % 4) == 2));
      chk("t2_mem_en", 32'(m1_en), 32'((k % 2) == 0));
      if ((k % 4) == 0) begin
        chk("t2_i_addr", m1_addr, 32'h44);
        q1.push_back('{1'b0, 1'b1, word(32'h44), cyc_n + 1});
      end
      if ((k % 4) == 2) begin
        chk("t2_d_addr", m1_addr, 32'h200);
        q1.push_back('{1'b1, 1'b1, word(32'h200), cyc_n + 1});
      end
      adv();
    end
    i_req1 = 1'b0; d_req1 = 1'b0;

    // Store then load back, latency 1.
    d_req1 = 1'b1; d_addr1 = 32'h100; d_wen1 = 4'hF; d_wdata1 = 32'hDEAD_BEEF;
    settle();
    chk("t3_d_gnt", 32'(d_gnt1), 32'd1);
    chk("t3_mem_wen", 32'(m1_wen), 32'hF);
    chk("t3_mem_wdata", m1_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_addr", m1_addr, 32'h100);
    q1.push_back('{1'b1, 1'b0, 32'h0, cyc_n + 1});
    adv();
    d_req1 = 1'b0; d_wen1 = 4'h0; d_wdata1 = '0;
    settle();
    chk("t3_wen_one_cycle", 32'(m1_wen), 32'd0);
    chk("t3_en_off", 32'(m1_en), 32'd0);
    adv();
    d_req1 = 1'b1;
    settle();
    chk("t3_load_gnt", 32'(d_gnt1), 32'd1);
    chk("t3_load_wen", 32'(m1_wen), 32'd0);
    q1.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, cyc_n + 1});
    adv();
    d_req1 = 1'b0;
    settle();
    adv();

    // Lone data requester, four back-to-back loads.
    d_req1 = 1'b1; d_addr1 = 32'h200;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t6_d_gnt", 32'(d_gnt1), 32'((k % 2) == 0));
      if ((k % 2) == 0) begin
        a = 32'h200 + 32'(4 * (k / 2));
        chk("t6_mem_addr", m1_addr, a);
        q1.push_back('{1'b1, 1'b1, word(a), cyc_n + 1});
      end
      adv();
      if ((k % 2) == 0) d_addr1 = d_addr1 + 32'd4;
    end
    d_req1 = 1'b0;

    // Latency 3 load; held request re-granted four cycles later.
    d_req3 = 1'b1; d_addr3 = 32'h8;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t4_d_gnt", 32'(d_gnt3), 32'(k == 0 || k == 4));
      chk("t4_mem_en", 32'(m3_en), 32'(k == 0 || k == 4));
      if (k == 0 || k == 4) q3.push_back('{1'b1, 1'b1, word(32'h8), cyc_n + 3});
      adv();
    end
    d_req3 = 1'b0;
    repeat (3) begin
      settle();
      adv();
    end

    // Reset mid-wait abandons the fetch; instruction priority returns.
    i_req3 = 1'b1; i_addr3 = 32'h40;
    settle();
    chk("t5_i_gnt", 32'(i_gnt3), 32'd1);
    adv();
    rst = 1'b1; d_req3 = 1'b1; d_addr3 = 32'hC;
    #1;
    chk("t5_rst_i_gnt", 32'(i_gnt3), 32'd0);
    chk("t5_rst_d_gnt", 32'(d_gnt3), 32'd0);
    chk("t5_rst_mem_en", 32'(m3_en), 32'd0);
    chk("t5_rst_rvalid", 32'(i_rvalid3 | d_rvalid3), 32'd0);
    chk("t5_rst_mem_addr", m3_addr, 32'd0);
    settle();
    adv();
    rst = 1'b0;
    settle();
    chk("t5_regrant_i", 32'(i_gnt3), 32'd1);
    chk("t5_regrant_d", 32'(d_gnt3), 32'd0);
    chk("t5_regrant_addr", m3_addr, 32'h40);
    q3.push_back('{1'b0, 1'b1, 32'h3C01_0001, cyc_n + 3});
    adv();
    i_req3 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      settle();
      chk("t5_wait_d_gnt", 32'(d_gnt3), 32'd0);
      adv();
    end
    settle();
    chk("t5_d_gnt", 32'(d_gnt3), 32'd1);
    q3.push_back('{1'b1, 1'b1, word(32'hC), cyc_n + 3});
    adv();
    d_req3 = 1'b0;
    repeat (4) begin
      settle();
      adv();
    end

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the CPU's instruction-fetch requester and its data (load/store) requester.
- Sits between the multicycle control/datapath and the unified memory, and replaces the separate instruction and data memory enables.
- Uses round-robin arbitration on contention and sequences each access through a fixed-latency wait.
- Returns a per-requester read-valid/ack pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata. Legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; held with i_addr until i_gnt.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with address/data/wen until d_gnt.
- d_addr  in  ADDR_W  data address.
- d_wen  in  4  byte write enables; 0000 means read.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory enable.
- mem_wen  out  4  memory byte write enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - state=IDLE, owner=DATA, last_grant=DATA, cnt=0.
  - All gnt/rvalid/mem_en/mem_wen outputs are 0; mem_addr and mem_wdata are 0.
- IDLE state, selection:
  - No request: all outputs 0, stay in IDLE.
  - Exactly one request: that requester wins.
  - Both requests: the winner is the requester that is not last_grant (round-robin). After reset the instruction side wins first.
- IDLE state, winning cycle (combinational from state and the requests):
  - Assert the winner's gnt and mem_en.
  - Drive mem_addr from the winner's address.
  - For a data win, drive mem_wen=d_wen and mem_wdata=d_wdata. For an instruction win, mem_wen=0000.
- IDLE state, register updates on the clock edge after the winning cycle:
  - owner<=winner, last_grant<=winner, cnt<=MEM_LATENCY, state<=WAIT.
- WAIT state:
  - gnt, mem_en and mem_wen are all 0; requests are ignored and held off.
  - cnt decrements each cycle.
  - When cnt==1, assert owner's rvalid for that cycle and route mem_rdata to owner's rdata; state<=IDLE.
- Latency and throughput:
  - With the grant in cycle N, rvalid is in cycle N+MEM_LATENCY.
  - The next grant is no earlier than N+MEM_LATENCY+1, so throughput is one access per MEM_LATENCY+1 cycles.
- Read data outputs:
  - i_rdata and d_rdata pass mem_rdata through.
  - Their value is meaningful only in their own rvalid cycle.
  - The non-owner's rdata is driven 0.
- Stores: d_rvalid pulses as a completion ack at the same latency as a load; d_rdata is don't-care in that cycle.
- Request dropped before grant: legal; no access is issued.
- Request after grant: the requester must deassert or present a new request only after its gnt.
- Same requester repeating with no contention: it is re-granted every MEM_LATENCY+1 cycles; last_grant does not block a lone requester.
- Reset mid-WAIT: the access is abandoned, no rvalid is issued, and the state returns to IDLE immediately.
- MEM_LATENCY outside 1..7: elaboration error via generate-time check.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings IDLE=1'b0, WAIT=1'b1;
  - owner encodings OWN_INST=1'b0, OWN_DATA=1'b1;
  - WEN_NONE=4'b0000.
- One natural sub-module, rr_pick2: a combinational two-way round-robin chooser.
  - Inputs: req0, req1, last.
  - Outputs: pick, any.
- The FSM, counter and muxing stay in mem_port_arbiter.

Test Plan:
1. Lone instruction read: i_req=1, i_addr=0x40, MEM_LATENCY=1, memory returns 0x3C010001 → i_gnt and mem_en in cycle 0 with mem_addr=0x40, mem_wen=0; i_rvalid=1 and i_rdata=0x3C010001 in cycle 1; no d_* activity.
2. Contention after reset: i_req=d_req=1 held continuously → grant order I, D, I, D. Grants in cycles 0, 2, 4, 6 with MEM_LATENCY=1. Each rvalid goes to the matching side only.
3. Store: d_req=1, d_addr=0x100, d_wen=1111, d_wdata=0xDEADBEEF → mem_wen=1111 and mem_wdata=0xDEADBEEF for exactly one cycle; d_rvalid one cycle later; a following load from 0x100 returns 0xDEADBEEF.
4. MEM_LATENCY=3, single data load at 0x8 → d_gnt in cycle N, d_rvalid only in cycle N+3, d_gnt low in N+1..N+3. A second d_req is granted at N+4.
5. Reset mid-access: MEM_LATENCY=3, grant fetch, assert reset in cycle N+1 for one cycle → outputs 0 asynchronously; no i_rvalid ever; after release an i_req is granted immediately and instruction priority is restored.
6. Lone data requester over 4 back-to-back loads, i_req=0 → all four granted at MEM_LATENCY+1 spacing; no stall caused by last_grant=DATA.
